muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_if.sv | 28 ++
 rtl/muldiv_ctrl.sv | 172 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: operation request and result handshake bundle for muldiv_ctrl.
// Request side:  in_valid/in_ready handshake, in_op, in_a (rs1), in_b (rs2), in_tag.
// Result side:   out_valid/out_ready handshake, out_result, out_tag.
// master drives requests and consumes results; slave is the muldiv_ctrl end.
interface muldiv_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV32M multiply/divide unit with a single in-flight operation.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   flush  - synchronous kill of the in-flight operation (beats accept and out_ready)
//   busy   - high whenever the controller is not idle
//   bus    - muldiv_ctrl_if.slave: request (in_*) and result (out_*) handshakes
// Ops: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
// Latency from the accept edge: multiply 2 cycles, divide 34 cycles.
// Build option MULDIV_DIV_BYPASS_EN: divide-by-zero and signed overflow skip the
// iterative divider and complete in 1 cycle; otherwise they run the full divide and
// the FIX state substitutes the architectural results.
module muldiv_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    output logic           busy,
    muldiv_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      dvs_q, dvs_d;
    logic [31:0]      res_q, res_d;

    // Magnitude of a value that may be two's complement; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

    // Architectural results for divide-by-zero and signed overflow.
    function automatic logic [31:0] spec_res(input logic is_rem, input logic [31:0] a,
                                             input logic dz);
        return is_rem ? (dz ? a : 32'h0) : (dz ? 32'hFFFF_FFFF : 32'h8000_0000);
    endfunction

    logic        acc;
    logic        in_sgn;
    logic        q_sgn;
    logic        dz_q;
    logic        ovf_q;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] prod;
    logic [32:0] sh;
    logic        ge;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign acc    = bus.in_valid && (state_q == IDLE) && !flush;
    // Even ops (div, rem) are the signed divides.
    assign in_sgn = !bus.in_op[0];
    assign q_sgn  = !op_q[0];

    // Multiplier: extend each operand to 64 bits according to its signedness; the low
    // 64 bits of the unsigned product are then the exact two's complement product.
    assign ea   = {{32{(op_q[1:0] != 2'b11) && a_q[31]}}, a_q};
    assign eb   = {{32{!op_q[1] && b_q[31]}}, b_q};
    assign prod = ea * eb;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign sh = {rem_q, quo_q[31]};
    assign ge = sh >= {1'b0, dvs_q};

    assign dz_q  = (b_q == 32'h0);
    assign ovf_q = q_sgn && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign q_fix = (q_sgn && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
    assign r_fix = (q_sgn && a_q[31]) ? -rem_q : rem_q;

`ifdef MULDIV_DIV_BYPASS_EN
    logic in_dz;
    logic in_ovf;
    assign in_dz  = (bus.in_b == 32'h0);
    assign in_ovf = in_sgn && (bus.in_a == 32'h8000_0000) && (bus.in_b == 32'hFFFF_FFFF);
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    op_d    = bus.in_op;
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    tag_d   = bus.in_tag;
                    quo_d   = mag(bus.in_a, in_sgn);
                    dvs_d   = mag(bus.in_b, in_sgn);
                    rem_d   = 32'h0;
                    cnt_d   = 5'd31;
                    state_d = bus.in_op[2] ? DIV : MUL;
`ifdef MULDIV_DIV_BYPASS_EN
                    if (bus.in_op[2] && (in_dz || in_ovf)) begin
                        res_d   = spec_res(bus.in_op[1], bus.in_a, in_dz);
                        state_d = DONE;
                    end
`endif
                end
            end
            MUL: begin
                res_d   = (op_q == 3'd0) ? prod[31:0] : prod[63:32];
                state_d = DONE;
            end
            DIV: begin
                rem_d   = ge ? 32'(sh - {1'b0, dvs_q}) : sh[31:0];
                quo_d   = {quo_q[30:0], ge};
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == 5'd0) ? FIX : DIV;
            end
            FIX: begin
                res_d   = (dz_q || ovf_q) ? spec_res(op_q[1], a_q, dz_q)
                                          : (op_q[1] ? r_fix : q_fix);
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = bus.out_valid ? res_q : 32'h0;
    assign bus.out_tag    = bus.out_valid ? tag_q : '0;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized self-checking bench for muldiv_ctrl against an arithmetic reference.
module tb_muldiv_ctrl;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic busy;
    int   n_tot = 0;
    int   n_bad = 0;

    muldiv_ctrl_if #(.TAG_W(TW)) bus ();
    muldiv_ctrl #(.TAG_W(TW)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua) * 64'(ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (op < 3'd4) return 2;
`ifdef MULDIV_DIV_BYPASS_EN
        if (special) return 1;
`else
        if (special) return 34;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TW-1:0] tag, input int hold);
        logic [31:0] er;
        int lat;
        int cyc;
        bit seen;
        er  = ref_res(op, a, b);
        lat = ref_lat(op, a, b);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'($urandom);
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_tag   = TW'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !bus.out_valid)
                chk({name, "_outs_zero"}, 64'({bus.out_result, bus.out_tag}), 64'h0);
            seen = bus.out_valid;
        end
        chk({name, "_lat"}, 64'(cyc), 64'(lat));
        chk({name, "_res"}, 64'(bus.out_result), 64'(er));
        chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        repeat (hold) begin
            @(negedge clk);
            chk({name, "_hold"}, 64'({bus.in_ready, busy, bus.out_valid, bus.out_result, bus.out_tag}),
                64'({1'b0, 1'b1, 1'b1, er, tag}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_bubble"}, 64'({bus.in_ready, bus.out_valid, busy}), 64'(3'b100));
    endtask

    task automatic start_div();
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd4;
        bus.in_a     = $urandom;
        bus.in_b     = 32'd3;
        bus.in_tag   = 5'd9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int spur;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_a      = 32'h0;
        bus.in_b      = 32'h0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_outs", 64'({bus.in_ready, bus.out_valid, busy, bus.out_result, bus.out_tag}),
            64'({1'b1, 1'b0, 1'b0, 32'h0, 5'h0}));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_neg1x2",   3'd0, 32'hFFFF_FFFF, 32'd2, 5'd1, 0);
        run_op("mulhu_neg1x2", 3'd3, 32'hFFFF_FFFF, 32'd2, 5'd2, 0);
        run_op("mulh_mixed",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 0);
        run_op("mulhsu_mixed", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
        run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        run_op("remu_7_2",     3'd7, 32'd7, 32'd2, 5'd7, 0);
        run_op("div_5_0",      3'd4, 32'd5, 32'd0, 5'd8, 0);
        run_op("rem_5_0",      3'd6, 32'd5, 32'd0, 5'd9, 0);
        run_op("divu_5_0",     3'd5, 32'd5, 32'd0, 5'd10, 0);
        run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
        run_op("divu_big",     3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
        run_op("hold_10",      3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd31, 10);

        // Flush mid-divide while a new request is offered.
        start_div();
        repeat (10) @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd5;
        bus.in_a     = 32'd55;
        bus.in_b     = 32'd5;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle", 64'({bus.in_ready, busy, bus.out_valid}), 64'(3'b100));
        @(negedge clk);
        chk("flush_noacc", 64'({bus.in_ready, busy, bus.out_valid}), 64'(3'b100));
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd14, 0);

        // Reset mid-divide.
        start_div();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 64'({bus.in_ready, bus.out_valid, busy, bus.out_result, bus.out_tag}),
            64'({1'b1, 1'b0, 1'b0, 32'h0, 5'h0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spur = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid || busy) spur++;
        end
        chk("rst_no_spur", 64'(spur), 64'h0);

        for (int i = 0; i < 40; i++)
            run_op("rand", 3'($urandom), pick(), pick(), TW'($urandom), $urandom_range(0, 3));

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
